// File: rtl/mcu_mem_responder.sv
// rtl/mcu_mem_responder.sv - in-order request queue and 32-bit local RAM responder for the MCU memory bus
//
// Ports:
//   CLK, RESET          clock; asynchronous active-low reset
//   ACT, CMD, SIZE      request valid, 1=read/0=write, 00=byte 01=half 1x=word
//   ADDRESS, DTi        45-bit byte address, right-aligned write data
//   HOLD                stall dequeue from the request queue
//   NEXT                queue can accept (request transfers on ACT&NEXT)
//   DRDY, DTo           one-cycle read-data pulse, right-aligned zero-extended data
//   ERR                 sticky out-of-window access flag
module mcu_mem_responder #(
    parameter logic [44:0] ADDR_BASE = 45'h0,
    parameter int          WORDS     = 1024,
    parameter int          QDEPTH    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ACT,
    input  logic        CMD,
    input  logic [1:0]  SIZE,
    input  logic [44:0] ADDRESS,
    input  logic [31:0] DTi,
    input  logic        HOLD,
    output logic        NEXT,
    output logic        DRDY,
    output logic [31:0] DTo,
    output logic        ERR
);

    localparam int          AW        = $clog2(WORDS);
    localparam int          QW        = $clog2(QDEPTH);
    localparam logic [44:0] WIN_BYTES = 45'(WORDS) << 2;
    localparam logic [QW:0] QFULL     = (QW+1)'(QDEPTH);

    typedef struct packed {
        logic        cmd;
        logic [1:0]  size;
        logic [44:0] addr;
        logic [31:0] data;
    } req_t;

    // ---------------- request queue ----------------
    req_t          q_mem [QDEPTH];
    logic [QW-1:0] wr_ptr;
    logic [QW-1:0] rd_ptr;
    logic [QW:0]   count;
    logic [QW:0]   count_nxt;
    logic          push;
    logic          pop;

    assign push = ACT & NEXT;
    assign pop  = (count != '0) & ~HOLD;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            NEXT   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            // Registered accept flag reflects occupancy after this edge, so a
            // pop on a full queue reopens it immediately.
            NEXT  <= (count_nxt < QFULL);
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge CLK) begin
        if (push)
            q_mem[wr_ptr] <= '{cmd: CMD, size: SIZE, addr: ADDRESS, data: DTi};
    end

    // ---------------- decode of queue head ----------------
    req_t        head;
    logic [44:0] off;
    logic        in_win;
    logic [3:0]  be;
    logic [31:0] wdata;

    assign head   = q_mem[rd_ptr];
    assign off    = head.addr - ADDR_BASE;
    assign in_win = (head.addr >= ADDR_BASE) && (off < WIN_BYTES);

    always_comb begin
        be    = 4'b1111;
        wdata = head.data;
        case (head.size)
            2'b00: begin
                be    = 4'b0001 << off[1:0];
                wdata = {4{head.data[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{head.data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = head.data;
            end
        endcase
    end

    // ---------------- E1: RAM access ----------------
    logic          e1_valid;
    logic          e1_rd;
    logic [1:0]    e1_size;
    logic [1:0]    e1_lane;
    logic [AW-1:0] e1_idx;
    logic          e1_win;
    logic [3:0]    e1_be;
    logic [31:0]   e1_wdata;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            e1_valid <= 1'b0;
            e1_rd    <= 1'b0;
            e1_size  <= '0;
            e1_lane  <= '0;
            e1_idx   <= '0;
            e1_win   <= 1'b0;
            e1_be    <= '0;
            e1_wdata <= '0;
        end else begin
            e1_valid <= pop;
            if (pop) begin
                e1_rd    <= head.cmd;
                e1_size  <= head.size;
                e1_lane  <= off[1:0];
                e1_idx   <= off[AW+1:2];
                e1_win   <= in_win;
                e1_be    <= be;
                e1_wdata <= wdata;
            end
        end
    end

    logic [31:0] ram [WORDS];
    logic [31:0] ram_q;

    // RAM is outside the reset domain so contents survive RESET.
    always_ff @(posedge CLK) begin
        if (e1_valid && !e1_rd && e1_win) begin
            for (int i = 0; i < 4; i++) begin
                if (e1_be[i])
                    ram[e1_idx][8*i +: 8] <= e1_wdata[8*i +: 8];
            end
        end
        ram_q <= ram[e1_idx];
    end

    // ---------------- E2: lane alignment and output ----------------
    logic        e2_valid;
    logic [1:0]  e2_size;
    logic [1:0]  e2_lane;
    logic        e2_win;
    logic [31:0] rd_data;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            e2_valid <= 1'b0;
            e2_size  <= '0;
            e2_lane  <= '0;
            e2_win   <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            e2_valid <= e1_valid & e1_rd;
            e2_size  <= e1_size;
            e2_lane  <= e1_lane;
            e2_win   <= e1_win;
            if (e1_valid && !e1_win)
                ERR <= 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (e2_win) begin
            case (e2_size)
                2'b00:   rd_data[7:0]  = ram_q[{e2_lane, 3'b000} +: 8];
                2'b01:   rd_data[15:0] = ram_q[{e2_lane[1], 4'b0000} +: 16];
                default: rd_data       = ram_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DRDY <= 1'b0;
            DTo  <= '0;
        end else begin
            DRDY <= e2_valid;
            if (e2_valid)
                DTo <= rd_data;
        end
    end

endmodule

// File: tb/tb_mcu_mem_responder.sv
// tb/tb_mcu_mem_responder.sv - scoreboard testbench for mcu_mem_responder
module tb_mcu_mem_responder;

    localparam logic [44:0] BASE = 45'h1000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ACT;
    logic        CMD;
    logic [1:0]  SIZE;
    logic [44:0] ADDRESS;
    logic [31:0] DTi;
    logic        HOLD;
    logic        NEXT;
    logic        DRDY;
    logic [31:0] DTo;
    logic        ERR;

    mcu_mem_responder #(.ADDR_BASE(BASE), .WORDS(16), .QDEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .ACT(ACT), .CMD(CMD), .SIZE(SIZE),
        .ADDRESS(ADDRESS), .DTi(DTi), .HOLD(HOLD), .NEXT(NEXT),
        .DRDY(DRDY), .DTo(DTo), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   drdy_count = 0;
    int   n_exp = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every DRDY pulse.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && DRDY === 1'b1) begin
            exp_t e;
            drdy_count++;
            if (sb.size() == 0) begin
                chk("unexpected_drdy", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("read_data", DTo, e.data);
                if (e.chk_lat)
                    chk("read_latency", 32'(cyc - e.acc), 32'd3);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit rd, input logic [1:0] sz, input logic [44:0] a,
                         input logic [31:0] d, input logic [31:0] exp,
                         input bit lat, input bit track);
        int n = 0;
        ACT = 1'b1; CMD = rd; SIZE = sz; ADDRESS = a; DTi = d;
        while (NEXT !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (NEXT !== 1'b1) begin
            chk("accept_timeout", 32'(NEXT), 32'd1);
        end else if (rd && track) begin
            sb.push_back('{data: exp, acc: cyc + 1, chk_lat: lat});
            n_exp++;
        end
        @(negedge CLK);
        ACT = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    int saved;

    initial begin
        RESET = 1'b0; ACT = 1'b1; CMD = 1'b1; SIZE = 2'b10;
        ADDRESS = BASE; DTi = '0; HOLD = 1'b0;

        // T1 reset
        repeat (3) @(negedge CLK);
        chk("t1_next_rst", 32'(NEXT), 32'd0);
        chk("t1_drdy_rst", 32'(DRDY), 32'd0);
        chk("t1_err_rst", 32'(ERR), 32'd0);
        chk("t1_dto_rst", DTo, 32'd0);
        RESET = 1'b1;
        #1 chk("t1_next_pre_edge", 32'(NEXT), 32'd0);
        @(negedge CLK);
        ACT = 1'b0;
        chk("t1_next_after_edge", 32'(NEXT), 32'd1);

        // T2 word write then read, latency 3
        issue(0, 2'b10, BASE + 8, 32'hDEADBEEF, '0, 0, 0);
        issue(1, 2'b10, BASE + 8, '0, 32'hDEADBEEF, 1, 1);
        drain();

        // T3 byte/half lanes
        issue(0, 2'b00, BASE + 45'hB, 32'hFFFFFF5A, '0, 0, 0);
        issue(0, 2'b01, BASE + 45'h5, 32'h1234CAFE, '0, 0, 0);
        issue(1, 2'b10, BASE + 45'h8, '0, 32'h5AADBEEF, 1, 1);
        issue(1, 2'b01, BASE + 45'hA, '0, 32'h00005AAD, 1, 1);
        issue(1, 2'b01, BASE + 45'hB, '0, 32'h00005AAD, 1, 1);
        issue(1, 2'b00, BASE + 45'h9, '0, 32'h000000BE, 1, 1);
        issue(1, 2'b01, BASE + 45'h4, '0, 32'h0000CAFE, 1, 1);
        drain();

        // T4 HOLD fills the queue, fifth request waits
        HOLD = 1'b1;
        saved = drdy_count;
        issue(1, 2'b10, BASE + 45'h8, '0, 32'h5AADBEEF, 0, 1);
        issue(1, 2'b01, BASE + 45'h4, '0, 32'h0000CAFE, 0, 1);
        issue(1, 2'b00, BASE + 45'hB, '0, 32'h0000005A, 0, 1);
        issue(1, 2'b00, BASE + 45'h8, '0, 32'h000000EF, 0, 1);
        chk("t4_next_full", 32'(NEXT), 32'd0);
        fork
            issue(1, 2'b01, BASE + 45'hA, '0, 32'h00005AAD, 0, 1);
            begin
                repeat (3) @(negedge CLK);
                chk("t4_next_held", 32'(NEXT), 32'd0);
                chk("t4_no_drdy_hold", 32'(drdy_count), 32'(saved));
                HOLD = 1'b0;
            end
        join
        drain();
        chk("t4_five_pulses", 32'(drdy_count - saved), 32'd5);

        // T5 out of window
        issue(0, 2'b10, BASE, 32'h01234567, '0, 0, 0);
        drain();
        chk("t5_err_clear", 32'(ERR), 32'd0);
        issue(1, 2'b10, BASE + 45'h40, '0, 32'h0, 1, 1);
        drain();
        chk("t5_err_set", 32'(ERR), 32'd1);
        issue(0, 2'b10, BASE + 45'h40, 32'h11111111, '0, 0, 0);
        issue(1, 2'b10, BASE, '0, 32'h01234567, 1, 1);
        issue(1, 2'b10, BASE - 45'h4, '0, 32'h0, 1, 1);
        drain();
        chk("t5_err_sticky", 32'(ERR), 32'd1);

        // T6 reset discards queued reads, RAM retained
        HOLD = 1'b1;
        issue(1, 2'b10, BASE + 45'h8, '0, '0, 0, 0);
        issue(1, 2'b10, BASE + 45'h4, '0, '0, 0, 0);
        issue(1, 2'b10, BASE, '0, '0, 0, 0);
        saved = drdy_count;
        RESET = 1'b0;
        #1 chk("t6_next_in_rst", 32'(NEXT), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        HOLD = 1'b0;
        @(negedge CLK);
        chk("t6_next_after", 32'(NEXT), 32'd1);
        chk("t6_err_cleared", 32'(ERR), 32'd0);
        repeat (8) @(negedge CLK);
        chk("t6_no_drdy", 32'(drdy_count), 32'(saved));
        issue(1, 2'b10, BASE + 45'h8, '0, 32'h5AADBEEF, 1, 1);
        issue(1, 2'b10, BASE, '0, 32'h01234567, 1, 1);
        drain();

        chk("total_drdy", 32'(drdy_count), 32'(n_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
